i_decode: RTL and testbench
===========================

I_DECODE -- requirements
Module: i_decode

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register and immediate data width.
REQ-002 Parameter ADDR_WIDTH, default 32: program counter width.
REQ-003 Parameter REG_COUNT, default 32: register file depth, fixed at 32 for RV32I.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-005 i_clk  in  1  sole clock; all state on rising edge.
REQ-006 i_reset  in  1  asynchronous active-high reset.
REQ-007 i_stall  in  1  hold ID outputs.
REQ-008 i_flush  in  1  replace next ID output with bubble.
REQ-009 i_IF_instr  in  32  fetched instruction.
REQ-010 i_IF_program_cntr, i_IF_program_cntr_next  in  ADDR_WIDTH  PC and PC+4 of instruction.
REQ-011 i_WB_reg_wr_en  in  1; i_WB_rd_addr  in  5; i_WB_rd_data  in  DATA_WIDTH: writeback port.
REQ-012 o_ID_rs1_data, o_ID_rs2_data  out  DATA_WIDTH: source operands.
REQ-013 o_ID_rs1_addr, o_ID_rs2_addr, o_ID_rd_addr  out  5: register indices.
REQ-014 o_ID_imm  out  DATA_WIDTH: sign-extended immediate.
REQ-015 o_ID_alu_ctrl  out  4; o_ID_alu_src_a  out  1 (1=PC); o_ID_alu_src_b  out  1 (1=imm).
REQ-016 o_ID_reg_wr_en, o_ID_mem_rd_en, o_ID_mem_wr_en, o_ID_branch, o_ID_jump, o_ID_illegal  out  1 each.
REQ-017 o_ID_result_sel  out  2 (00 ALU, 01 memory, 10 PC+4); o_ID_funct3  out  3.
REQ-018 o_ID_program_cntr, o_ID_program_cntr_next  out  ADDR_WIDTH: registered PC pair.

Function
REQ-019 All o_ID_* outputs SHALL be registered; latency from i_IF_* to o_ID_* is exactly one cycle.
REQ-020 Register file: 32 x DATA_WIDTH, two combinational read ports addressed by instr[19:15] and instr[24:20], one write port written on the rising edge when i_WB_reg_wr_en=1.
REQ-021 x0 SHALL read 0; writes to x0 SHALL be discarded.
REQ-022 A WB write and a same-cycle read of the same nonzero register SHALL capture i_WB_rd_data (write-through bypass).
REQ-023 Opcode classes SHALL be R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-024 Immediates SHALL be I, S, B, U and J formats per RV32I, sign-extended from instr[31]; B and J SHALL have bit0=0; R-type imm SHALL be 0.
REQ-025 alu_ctrl encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
REQ-026 R-type: funct3 with instr[30] selects SUB and SRA. I-ALU: instr[30] is honoured only for funct3=101; ADDI never decodes as SUB.
REQ-027 LOAD/STORE/JALR SHALL use ADD, alu_src_b=1. BRANCH SHALL use SUB, alu_src_b=0. LUI SHALL use PASS_B. AUIPC SHALL use ADD with alu_src_a=1.
REQ-028 reg_wr_en=1 SHALL apply to R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC, and SHALL be forced to 0 when rd=0.
REQ-029 result_sel SHALL be 01 for LOAD, 10 for JAL/JALR, 00 otherwise. jump=1 for JAL/JALR; branch=1 for BRANCH.
REQ-030 An unknown opcode SHALL produce a bubble with o_ID_illegal=1.
REQ-031 Bubble: all enable, branch and jump outputs 0, rd_addr=0, alu_ctrl=ADD, illegal=0 unless set by REQ-030.
REQ-032 i_stall=1 SHALL hold all outputs, except that rs1/rs2 data SHALL update when WB writes a nonzero register matching the held rs1/rs2 address.
REQ-033 i_flush=1 SHALL load a bubble at the next edge; flush SHALL take priority over stall.

Reset
REQ-034 While i_reset=1, all o_ID_* outputs SHALL be 0 and all 32 registers SHALL be cleared to 0, asynchronously.
REQ-035 The first decode after reset deassertion SHALL occur at the first rising edge with i_reset=0.
REQ-036 Reset asserted mid-stall or mid-flush SHALL override both.

Verification
REQ-037 WB x5=0x0000_00AA; then ADD x3,x5,x0 -> next cycle rs1_data=0xAA, alu_ctrl=0, reg_wr_en=1, rd=3.
REQ-038 ADDI x1,x0,-1 (0xFFF00093) -> imm=0xFFFF_FFFF, alu_src_b=1, alu_ctrl=0; BEQ with offset -4 -> imm=0xFFFF_FFFC, branch=1.
REQ-039 WB x7=0x1234 in the same cycle as decoding SUB x1,x7,x7 -> rs1_data=rs2_data=0x1234, alu_ctrl=1.
REQ-040 i_stall=1 for 3 cycles with WB writing the held rs2 -> all other outputs constant, rs2_data updated; stall+flush together -> bubble.
REQ-041 Opcode 0x7F -> illegal=1, all enables 0; WB to x0=0xFFFF -> later x0 read returns 0.
REQ-042 Reset pulse mid-stream -> outputs 0 immediately (no clock edge); registers read 0 afterwards.

Source files
------------

// File: rtl/i_decode.sv
// RV32I instruction-decode stage: 32-entry register file, immediate and control
// decode, and the registered ID pipeline outputs with stall/flush handling.
module i_decode #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [31:0]           i_IF_instr,
  input  logic [ADDR_WIDTH-1:0] i_IF_program_cntr,
  input  logic [ADDR_WIDTH-1:0] i_IF_program_cntr_next,
  input  logic                  i_WB_reg_wr_en,
  input  logic [4:0]            i_WB_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_WB_rd_data,
  output logic [DATA_WIDTH-1:0] o_ID_rs1_data,
  output logic [DATA_WIDTH-1:0] o_ID_rs2_data,
  output logic [4:0]            o_ID_rs1_addr,
  output logic [4:0]            o_ID_rs2_addr,
  output logic [4:0]            o_ID_rd_addr,
  output logic [DATA_WIDTH-1:0] o_ID_imm,
  output logic [3:0]            o_ID_alu_ctrl,
  output logic                  o_ID_alu_src_a,
  output logic                  o_ID_alu_src_b,
  output logic                  o_ID_reg_wr_en,
  output logic                  o_ID_mem_rd_en,
  output logic                  o_ID_mem_wr_en,
  output logic                  o_ID_branch,
  output logic                  o_ID_jump,
  output logic                  o_ID_illegal,
  output logic [1:0]            o_ID_result_sel,
  output logic [2:0]            o_ID_funct3,
  output logic [ADDR_WIDTH-1:0] o_ID_program_cntr,
  output logic [ADDR_WIDTH-1:0] o_ID_program_cntr_next
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic [4:0]            rd_addr;
    logic [DATA_WIDTH-1:0] imm;
    logic [3:0]            alu_ctrl;
    logic                  alu_src_a;
    logic                  alu_src_b;
    logic                  reg_wr_en;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic                  branch;
    logic                  jump;
    logic                  illegal;
    logic [1:0]            result_sel;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
  } id_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [6:0]            opcode;
  logic [4:0]            rs1_a, rs2_a, rd_a;
  logic [2:0]            funct3;
  logic                  wb_wr;
  logic [DATA_WIDTH-1:0] rs1_rd, rs2_rd;
  logic [31:0]           imm32;
  logic                  wr, illegal;
  id_t                   dec, nxt, q;

  assign opcode = i_IF_instr[6:0];
  assign rd_a   = i_IF_instr[11:7];
  assign funct3 = i_IF_instr[14:12];
  assign rs1_a  = i_IF_instr[19:15];
  assign rs2_a  = i_IF_instr[24:20];
  assign wb_wr  = i_WB_reg_wr_en && (i_WB_rd_addr != 5'd0);

  // Register file; x0 is never written.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_wr) begin
      regs[i_WB_rd_addr] <= i_WB_rd_data;
    end
  end

  // Read ports with write-through bypass from the WB port.
  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    if (rs1_a != 5'd0) rs1_rd = (wb_wr && i_WB_rd_addr == rs1_a) ? i_WB_rd_data : regs[rs1_a];
    if (rs2_a != 5'd0) rs2_rd = (wb_wr && i_WB_rd_addr == rs2_a) ? i_WB_rd_data : regs[rs2_a];
  end

  always_comb begin
    dec          = '0;
    imm32        = '0;
    wr           = 1'b0;
    illegal      = 1'b0;
    dec.rs1_data = rs1_rd;
    dec.rs2_data = rs2_rd;
    dec.rs1_addr = rs1_a;
    dec.rs2_addr = rs2_a;
    dec.funct3   = funct3;
    dec.pc       = i_IF_program_cntr;
    dec.pc_next  = i_IF_program_cntr_next;
    dec.alu_ctrl = ALU_ADD;
    case (opcode)
      OP_R: begin
        dec.alu_ctrl = alu_op(funct3, i_IF_instr[30]);
        wr = 1'b1;
      end
      OP_IALU: begin
        dec.alu_ctrl  = alu_op(funct3, (funct3 == 3'b101) && i_IF_instr[30]);
        dec.alu_src_b = 1'b1;
        wr = 1'b1;
        imm32 = {{20{i_IF_instr[31]}}, i_IF_instr[31:20]};
      end
      OP_LOAD: begin
        dec.alu_src_b  = 1'b1;
        dec.mem_rd_en  = 1'b1;
        dec.result_sel = 2'b01;
        wr = 1'b1;
        imm32 = {{20{i_IF_instr[31]}}, i_IF_instr[31:20]};
      end
      OP_STORE: begin
        dec.alu_src_b = 1'b1;
        dec.mem_wr_en = 1'b1;
        imm32 = {{20{i_IF_instr[31]}}, i_IF_instr[31:25], i_IF_instr[11:7]};
      end
      OP_BRANCH: begin
        dec.alu_ctrl = ALU_SUB;
        dec.branch   = 1'b1;
        imm32 = {{19{i_IF_instr[31]}}, i_IF_instr[31], i_IF_instr[7], i_IF_instr[30:25],
                 i_IF_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        dec.alu_src_a  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_sel = 2'b10;
        wr = 1'b1;
        imm32 = {{11{i_IF_instr[31]}}, i_IF_instr[31], i_IF_instr[19:12], i_IF_instr[20],
                 i_IF_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.alu_src_b  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_sel = 2'b10;
        wr = 1'b1;
        imm32 = {{20{i_IF_instr[31]}}, i_IF_instr[31:20]};
      end
      OP_LUI: begin
        dec.alu_ctrl  = ALU_PASS_B;
        dec.alu_src_b = 1'b1;
        wr = 1'b1;
        imm32 = {i_IF_instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        wr = 1'b1;
        imm32 = {i_IF_instr[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
    dec.imm       = DATA_WIDTH'($signed(imm32));
    dec.reg_wr_en = wr && (rd_a != 5'd0);
    dec.rd_addr   = dec.reg_wr_en ? rd_a : 5'd0;
    // Unknown opcode: bubble that still carries its PC for trap handling.
    if (illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      dec.pc      = i_IF_program_cntr;
      dec.pc_next = i_IF_program_cntr_next;
    end
  end

  // Flush beats stall; a stalled entry still tracks WB writes to its sources.
  always_comb begin
    nxt = dec;
    if (i_flush) begin
      nxt = '0;
    end else if (i_stall) begin
      nxt = q;
      if (wb_wr && i_WB_rd_addr == q.rs1_addr) nxt.rs1_data = i_WB_rd_data;
      if (wb_wr && i_WB_rd_addr == q.rs2_addr) nxt.rs2_data = i_WB_rd_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) q <= '0;
    else         q <= nxt;
  end

  assign o_ID_rs1_data          = q.rs1_data;
  assign o_ID_rs2_data          = q.rs2_data;
  assign o_ID_rs1_addr          = q.rs1_addr;
  assign o_ID_rs2_addr          = q.rs2_addr;
  assign o_ID_rd_addr           = q.rd_addr;
  assign o_ID_imm               = q.imm;
  assign o_ID_alu_ctrl          = q.alu_ctrl;
  assign o_ID_alu_src_a         = q.alu_src_a;
  assign o_ID_alu_src_b         = q.alu_src_b;
  assign o_ID_reg_wr_en         = q.reg_wr_en;
  assign o_ID_mem_rd_en         = q.mem_rd_en;
  assign o_ID_mem_wr_en         = q.mem_wr_en;
  assign o_ID_branch            = q.branch;
  assign o_ID_jump              = q.jump;
  assign o_ID_illegal           = q.illegal;
  assign o_ID_result_sel        = q.result_sel;
  assign o_ID_funct3            = q.funct3;
  assign o_ID_program_cntr      = q.pc;
  assign o_ID_program_cntr_next = q.pc_next;

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: directed instructions push hand-computed
// expectations; a negedge monitor pops and compares them when they fall due.
module tb_i_decode;

  localparam logic [5:0] M_DATA = 6'h01;
  localparam logic [5:0] M_IMM  = 6'h02;
  localparam logic [5:0] M_PC   = 6'h04;
  localparam logic [5:0] M_CTRL = 6'h08;
  localparam logic [5:0] M_SRC  = 6'h10;
  localparam logic [5:0] M_FLD  = 6'h20;
  localparam logic [5:0] M_ALL  = 6'h3F;
  localparam logic [31:0] FILL  = 32'h0000_0013;

  typedef struct {
    string       name;
    int          due;
    logic [5:0]  mask;
    logic [31:0] rs1d, rs2d, imm, pc, pcn;
    logic [4:0]  rs1a, rs2a, rd;
    logic [3:0]  alu;
    logic        sa, sb, wr, mrd, mwr, br, jmp, ill;
    logic [1:0]  rsel;
    logic [2:0]  f3;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, wb_en;
  logic [31:0] instr, pcv, pcnv, wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] rs1d, rs2d, imm, opc, opcn;
  logic [4:0]  rs1a, rs2a, rd;
  logic [3:0]  alu;
  logic        sa, sb, wr, mrd, mwr, br, jmp, ill;
  logic [1:0]  rsel;
  logic [2:0]  f3;

  exp_t        q[$];
  exp_t        m;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] pc_ctr = 32'h100;

  i_decode dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
    .i_IF_instr(instr), .i_IF_program_cntr(pcv), .i_IF_program_cntr_next(pcnv),
    .i_WB_reg_wr_en(wb_en), .i_WB_rd_addr(wb_addr), .i_WB_rd_data(wb_data),
    .o_ID_rs1_data(rs1d), .o_ID_rs2_data(rs2d), .o_ID_rs1_addr(rs1a),
    .o_ID_rs2_addr(rs2a), .o_ID_rd_addr(rd), .o_ID_imm(imm), .o_ID_alu_ctrl(alu),
    .o_ID_alu_src_a(sa), .o_ID_alu_src_b(sb), .o_ID_reg_wr_en(wr),
    .o_ID_mem_rd_en(mrd), .o_ID_mem_wr_en(mwr), .o_ID_branch(br), .o_ID_jump(jmp),
    .o_ID_illegal(ill), .o_ID_result_sel(rsel), .o_ID_funct3(f3),
    .o_ID_program_cntr(opc), .o_ID_program_cntr_next(opcn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, string f, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", n, f, got, exp);
    end
  endfunction

  function automatic exp_t blank(string n);
    exp_t e;
    e.name = n; e.due = 0; e.mask = '0;
    e.rs1d = '0; e.rs2d = '0; e.imm = '0; e.pc = '0; e.pcn = '0;
    e.rs1a = '0; e.rs2a = '0; e.rd = '0; e.alu = '0;
    e.sa = 1'b0; e.sb = 1'b0; e.wr = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0;
    e.br = 1'b0; e.jmp = 1'b0; e.ill = 1'b0; e.rsel = '0; e.f3 = '0;
    return e;
  endfunction

  // Full-check expectation; register fields come from the hand encoding.
  function automatic exp_t op(string n, logic [31:0] ins);
    exp_t e;
    e = blank(n);
    e.mask = M_ALL;
    e.rs1a = ins[19:15];
    e.rs2a = ins[24:20];
    e.f3   = ins[14:12];
    e.pc   = pc_ctr;
    e.pcn  = pc_ctr + 32'd4;
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic st, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input exp_t e);
    instr = ins; stall = st; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    pcv = pc_ctr; pcnv = pc_ctr + 32'd4; pc_ctr = pc_ctr + 32'd4;
    if (e.mask != 6'h0) begin
      e.due = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic st, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input exp_t e);
    @(posedge clk);
    #1;
    drive(ins, st, fl, we, wa, wd, e);
  endtask

  // Monitor: compare every expectation that has fallen due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      m = q.pop_front();
      chk(m.name, "due_cycle", 32'(cyc), 32'(m.due));
      if ((m.mask & M_DATA) != 6'h0) begin
        chk(m.name, "rs1_data", rs1d, m.rs1d);
        chk(m.name, "rs2_data", rs2d, m.rs2d);
      end
      if ((m.mask & M_IMM) != 6'h0) chk(m.name, "imm", imm, m.imm);
      if ((m.mask & M_PC) != 6'h0) begin
        chk(m.name, "pc", opc, m.pc);
        chk(m.name, "pc_next", opcn, m.pcn);
      end
      if ((m.mask & M_CTRL) != 6'h0) begin
        chk(m.name, "alu_ctrl", 32'(alu), 32'(m.alu));
        chk(m.name, "rd_addr", 32'(rd), 32'(m.rd));
        chk(m.name, "enables", 32'({wr, mrd, mwr, br, jmp}),
            32'({m.wr, m.mrd, m.mwr, m.br, m.jmp}));
        chk(m.name, "illegal", 32'(ill), 32'(m.ill));
      end
      if ((m.mask & M_SRC) != 6'h0)
        chk(m.name, "src_a_b_rsel", 32'({sa, sb, rsel}), 32'({m.sa, m.sb, m.rsel}));
      if ((m.mask & M_FLD) != 6'h0)
        chk(m.name, "rs_addr_f3", 32'({rs1a, rs2a, f3}), 32'({m.rs1a, m.rs2a, m.f3}));
    end
  end

  exp_t e, ea, h, none;

  initial begin
    none = blank("none");
    rst = 1'b1; stall = 1'b0; flush = 1'b0; instr = FILL;
    pcv = '0; pcnv = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    @(posedge clk); #1;
    e = blank("reset"); e.mask = M_ALL; e.due = cyc; q.push_back(e);

    // First decode at the first edge with reset low.
    @(posedge clk); #1;
    rst = 1'b0;
    e = op("addi_m1", 32'hFFF0_0093);
    e.imm = 32'hFFFF_FFFF; e.sb = 1'b1; e.wr = 1'b1; e.rd = 5'd1;
    drive(32'hFFF0_0093, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    issue(FILL, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA, none);
    e = op("add_x3", 32'h0002_81B3);
    e.rs1d = 32'hAA; e.wr = 1'b1; e.rd = 5'd3;
    issue(32'h0002_81B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    e = op("beq_m4", 32'hFE20_8EE3);
    e.imm = 32'hFFFF_FFFC; e.br = 1'b1; e.alu = 4'd1;
    issue(32'hFE20_8EE3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    e = op("sub_bypass", 32'h4073_80B3);
    e.rs1d = 32'h1234; e.rs2d = 32'h1234; e.alu = 4'd1; e.wr = 1'b1; e.rd = 5'd1;
    issue(32'h4073_80B3, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234, e);

    e = op("addi_b30", 32'h4000_0093);
    e.imm = 32'h400; e.sb = 1'b1; e.wr = 1'b1; e.rd = 5'd1;
    issue(32'h4000_0093, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    e = op("srai", 32'h4030_D093);
    e.imm = 32'h403; e.alu = 4'd7; e.sb = 1'b1; e.wr = 1'b1; e.rd = 5'd1;
    issue(32'h4030_D093, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    e = op("lui", 32'h1234_52B7);
    e.imm = 32'h1234_5000; e.alu = 4'd10; e.sb = 1'b1; e.wr = 1'b1; e.rd = 5'd5;
    issue(32'h1234_52B7, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    e = op("auipc", 32'h0000_1317);
    e.imm = 32'h1000; e.sa = 1'b1; e.sb = 1'b1; e.wr = 1'b1; e.rd = 5'd6;
    issue(32'h0000_1317, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    e = op("sw_m8", 32'hFE20_AC23);
    e.imm = 32'hFFFF_FFF8; e.mwr = 1'b1; e.sb = 1'b1;
    issue(32'hFE20_AC23, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    e = op("lw", 32'h00C3_A483);
    e.rs1d = 32'h1234; e.imm = 32'd12; e.mrd = 1'b1; e.wr = 1'b1; e.rd = 5'd9;
    e.sb = 1'b1; e.rsel = 2'b01;
    issue(32'h00C3_A483, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    e = op("jalr", 32'h0041_00E7);
    e.imm = 32'd4; e.jmp = 1'b1; e.wr = 1'b1; e.rd = 5'd1; e.sb = 1'b1; e.rsel = 2'b10;
    issue(32'h0041_00E7, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    // Stall with WB hitting held sources, then stall+flush.
    issue(FILL, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11, none);
    issue(FILL, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22, none);
    ea = op("add_x4", 32'h0020_8233);
    ea.rs1d = 32'h11; ea.rs2d = 32'h22; ea.wr = 1'b1; ea.rd = 5'd4;
    issue(32'h0020_8233, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, ea);
    h = ea; h.name = "stall1"; h.rs2d = 32'h99;
    issue(32'h4073_80B3, 1'b1, 1'b0, 1'b1, 5'd2, 32'h99, h);
    h.name = "stall2"; h.rs2d = 32'h9A;
    issue(32'h4073_80B3, 1'b1, 1'b0, 1'b1, 5'd2, 32'h9A, h);
    h.name = "stall3"; h.rs2d = 32'h9B;
    issue(32'h4073_80B3, 1'b1, 1'b0, 1'b1, 5'd2, 32'h9B, h);
    h.name = "stall_other";
    issue(32'h4073_80B3, 1'b1, 1'b0, 1'b1, 5'd3, 32'h55, h);
    h.name = "stall_rs1"; h.rs1d = 32'h77;
    issue(32'h4073_80B3, 1'b1, 1'b0, 1'b1, 5'd1, 32'h77, h);
    e = blank("stall_flush"); e.mask = M_CTRL;
    issue(32'h4073_80B3, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, e);

    e = blank("flush"); e.mask = M_CTRL;
    issue(32'h0002_81B3, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, e);

    e = blank("illegal"); e.mask = M_CTRL; e.ill = 1'b1;
    issue(32'h0000_017F, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    // x0 stays zero through both bypass and stored paths.
    e = op("x0_bypass", 32'h0000_01B3);
    e.wr = 1'b1; e.rd = 5'd3;
    issue(32'h0000_01B3, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF, e);
    issue(FILL, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF, none);
    e = op("x0_read", 32'h0000_01B3);
    e.wr = 1'b1; e.rd = 5'd3;
    issue(32'h0000_01B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    // Reset in the middle of a stall clears outputs without a clock edge.
    e = op("add_x3_pre", 32'h0002_81B3);
    e.rs1d = 32'hAA; e.wr = 1'b1; e.rd = 5'd3;
    issue(32'h0002_81B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);
    issue(FILL, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, none);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst", "rs1_data", rs1d, 32'h0);
    chk("async_rst", "reg_wr_en", 32'(wr), 32'h0);
    chk("async_rst", "rd_addr", 32'(rd), 32'h0);
    chk("async_rst", "pc", opc, 32'h0);
    e = blank("reset_mid"); e.mask = M_ALL; e.due = cyc + 1; q.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0;
    e = op("add_x3_post", 32'h0002_81B3);
    e.wr = 1'b1; e.rd = 5'd3;
    drive(32'h0002_81B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, e);

    repeat (3) @(posedge clk);
    #1;
    chk("end", "queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
